// File: rtl/prio_dispatcher_pkg.sv
// Shared helpers for the priority dispatcher.
package prio_dispatcher_pkg;

    // Bits needed to count 0..max_out inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_out);
        return (max_out < 1) ? 1 : $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary index encoder; all-zero input yields index 0.
module onehot_to_bin #(
    parameter int unsigned OneHotWidth = 4,
    localparam int unsigned BinWidth = (OneHotWidth > 1) ? $clog2(OneHotWidth) : 1
) (
    input  logic [OneHotWidth-1:0] onehot_i,
    output logic [BinWidth-1:0]    bin_o
);

    always_comb begin
        bin_o = '0;
        for (int unsigned i = 0; i < OneHotWidth; i++) begin
            if (onehot_i[i]) begin
                bin_o = bin_o | BinWidth'(i);
            end
        end
    end

endmodule

// File: rtl/prio_dispatcher_credit.sv
// Saturating outstanding-item counter for one dispatch target.
module prio_dispatcher_credit
    import prio_dispatcher_pkg::*;
#(
    parameter int unsigned MAX_OUT = 2,
    localparam int unsigned CntW = cnt_width(MAX_OUT)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            avail_o
);

    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && cnt_q != MaxCnt) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign avail_o = cnt_q < MaxCnt;

    // A credit returned with nothing outstanding, or a dispatch into a full target, is a bug.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(dec_i && !inc_i && cnt_q == '0));
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(inc_i && !dec_i && cnt_q == MaxCnt));

endmodule

// File: rtl/prio_dispatcher.sv
// Single-entry stage dispatching each item to the lowest-index target with free credit.
module prio_dispatcher
    import prio_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_TGT    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_OUT    = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_WIDTH-1:0]      in_data_i,
    output logic [NUM_TGT-1:0]         out_valid_o,
    input  logic [NUM_TGT-1:0]         out_ready_i,
    output logic [DATA_WIDTH-1:0]      out_data_o,
    output logic [$clog2(NUM_TGT)-1:0] out_idx_o,
    input  logic [NUM_TGT-1:0]         done_i,
    output logic                       busy_o
);

    localparam int unsigned IdxW = $clog2(NUM_TGT);
    localparam int unsigned CntW = cnt_width(MAX_OUT);

    logic                  buf_valid_q;
    logic [DATA_WIDTH-1:0] buf_data_q;
    logic                  lock_q;
    logic [IdxW-1:0]       lock_idx_q;

    logic [NUM_TGT-1:0] avail, onehot, hs;
    logic [IdxW-1:0]    sel, idx;
    logic               out_hs, any_cnt;
    logic [CntW-1:0]    cnt [NUM_TGT];

    for (genvar g = 0; g < NUM_TGT; g++) begin : g_tgt
        prio_dispatcher_credit #(
            .MAX_OUT(MAX_OUT)
        ) u_credit (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .inc_i  (hs[g]),
            .dec_i  (done_i[g]),
            .cnt_o  (cnt[g]),
            .avail_o(avail[g])
        );

        if (g == 0) begin : g_first
            assign onehot[g] = avail[g];
        end else begin : g_rest
            assign onehot[g] = avail[g] & ~|avail[g-1:0];
        end
    end

    onehot_to_bin #(
        .OneHotWidth(NUM_TGT)
    ) u_sel_enc (
        .onehot_i(onehot),
        .bin_o   (sel)
    );

    // Once presented, the item stays on its target even if a lower one frees up.
    assign idx = lock_q ? lock_idx_q : sel;

    always_comb begin
        out_valid_o = '0;
        any_cnt     = 1'b0;
        for (int unsigned k = 0; k < NUM_TGT; k++) begin
            out_valid_o[k] = buf_valid_q &
                             (lock_q ? (IdxW'(k) == lock_idx_q) : (avail[k] & onehot[k]));
            any_cnt = any_cnt | (|cnt[k]);
        end
    end

    assign hs         = out_valid_o & out_ready_i;
    assign out_hs     = |hs;
    assign in_ready_o = ~buf_valid_q | out_hs;
    assign out_data_o = buf_data_q;
    assign out_idx_o  = idx;
    assign busy_o     = buf_valid_q | any_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
        end else if (flush_i) begin
            buf_valid_q <= 1'b0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
        end else begin
            if (in_valid_i && in_ready_o) begin
                buf_valid_q <= 1'b1;
                buf_data_q  <= in_data_i;
            end else if (out_hs) begin
                buf_valid_q <= 1'b0;
            end
            if (out_hs) begin
                lock_q <= 1'b0;
            end else if (buf_valid_q && |out_valid_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= idx;
            end
        end
    end

endmodule

// File: tb/tb_prio_dispatcher.sv
// Self-checking bench for prio_dispatcher: vector tables plus directed lock/flush sequences.
module tb_prio_dispatcher;

    localparam int unsigned NT = 4;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [NT-1:0] out_valid;
    logic [NT-1:0] out_ready = '0;
    logic [DW-1:0] out_data;
    logic [1:0]    out_idx;
    logic [NT-1:0] done = '0;
    logic          busy;

    prio_dispatcher #(
        .NUM_TGT   (NT),
        .DATA_WIDTH(DW),
        .MAX_OUT   (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_idx_o  (out_idx),
        .done_i     (done),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic [NT-1:0] ordy;
        logic [NT-1:0] dn;
        logic [NT-1:0] ov;
        logic [1:0]    idx;
        logic          ir;
        logic          bsy;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;

    function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic [NT-1:0] ordy,
                                logic [NT-1:0] dn, logic [NT-1:0] ov, logic [1:0] idx,
                                logic ir, logic bsy);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.dn = dn;
        v.ov = ov; v.idx = idx; v.ir = ir; v.bsy = bsy;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check just after, track the scoreboard from expectations.
    task automatic step(input string name, input logic fl, input vec_t v);
        logic [DW-1:0] e;
        @(negedge clk);
        flush     = fl;
        in_valid  = v.iv;
        in_data   = v.d;
        out_ready = v.ordy;
        done      = v.dn;
        #1;
        check({name, ".out_valid"}, DW'(out_valid), DW'(v.ov));
        check({name, ".out_idx"}, DW'(out_idx), DW'(v.idx));
        check({name, ".in_ready"}, DW'(in_ready), DW'(v.ir));
        check({name, ".busy"}, DW'(busy), DW'(v.bsy));
        if ((v.ov & v.ordy) != '0) begin
            if (exp_q.size() == 0) begin
                check({name, ".sb_underflow"}, DW'(1), DW'(0));
            end else begin
                e = exp_q.pop_front();
                check({name, ".out_data"}, out_data, e);
            end
        end
        if (fl) exp_q.delete();
        else if (v.iv && v.ir) exp_q.push_back(v.d);
    endtask

    task automatic run_table(input string name);
        foreach (vecs[i]) step($sformatf("%s[%0d]", name, i), 1'b0, vecs[i]);
        vecs.delete();
    endtask

    initial begin
        #2;
        check("rst.out_valid", DW'(out_valid), '0);
        check("rst.out_idx", DW'(out_idx), '0);
        check("rst.out_data", out_data, '0);
        check("rst.in_ready", DW'(in_ready), DW'(1));
        check("rst.busy", DW'(busy), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic dispatch: A, B to target 0, C to target 1, then credits returned.
        vecs.push_back(mk(1, 32'hA, 4'hF, 4'h0, 4'h0, 0, 1, 0));
        vecs.push_back(mk(1, 32'hB, 4'hF, 4'h0, 4'h1, 0, 1, 1));
        vecs.push_back(mk(1, 32'hC, 4'hF, 4'h0, 4'h1, 0, 1, 1));
        vecs.push_back(mk(0, 32'h0, 4'hF, 4'h0, 4'h2, 1, 1, 1));
        vecs.push_back(mk(0, 32'h0, 4'hF, 4'h0, 4'h0, 1, 1, 1));
        vecs.push_back(mk(0, 32'h0, 4'hF, 4'h1, 4'h0, 1, 1, 1));
        vecs.push_back(mk(0, 32'h0, 4'hF, 4'h1, 4'h0, 0, 1, 1));
        vecs.push_back(mk(0, 32'h0, 4'hF, 4'h2, 4'h0, 0, 1, 1));
        vecs.push_back(mk(0, 32'h0, 4'hF, 4'h0, 4'h0, 0, 1, 0));
        run_table("basic");

        // All saturated: 8 items fill 4x2 credits, the 9th waits for done on target 3.
        vecs.push_back(mk(1, 32'h100, 4'hF, 4'h0, 4'h0, 0, 1, 0));
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mk(1, 32'h100 + DW'(k), 4'hF, 4'h0, 4'(1 << ((k - 1) / 2)),
                              2'((k - 1) / 2), 1, 1));
        end
        vecs.push_back(mk(1, 32'h109, 4'hF, 4'h0, 4'h0, 0, 0, 1));
        vecs.push_back(mk(1, 32'h109, 4'hF, 4'h8, 4'h0, 0, 0, 1));
        vecs.push_back(mk(1, 32'h109, 4'hF, 4'h0, 4'h8, 3, 1, 1));
        vecs.push_back(mk(0, 32'h0, 4'hF, 4'h0, 4'h0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0, 4'hF, 4'hF, 4'h0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0, 4'hF, 4'hF, 4'h1, 0, 1, 1));
        vecs.push_back(mk(0, 32'h0, 4'hF, 4'h1, 4'h0, 0, 1, 1));
        vecs.push_back(mk(0, 32'h0, 4'hF, 4'h0, 4'h0, 0, 1, 0));
        run_table("sat");

        // Lock: target 0 holds off three cycles while target 1 is free.
        step("lock0", 0, mk(1, 32'h200, 4'hE, 4'h0, 4'h0, 0, 1, 0));
        for (int k = 0; k < 3; k++) step("lock_hold", 0, mk(0, 0, 4'hE, 4'h0, 4'h1, 0, 0, 1));
        step("lock_hs", 0, mk(0, 0, 4'hF, 4'h0, 4'h1, 0, 1, 1));
        step("lock_ret", 0, mk(0, 0, 4'hF, 4'h1, 4'h0, 0, 1, 1));
        step("lock_idle", 0, mk(0, 0, 4'hF, 4'h0, 4'h0, 0, 1, 0));

        // Lock vs. freed credit: item locked on target 2 must not move to target 0.
        step("steal0", 0, mk(1, 32'h300, 4'hF, 4'h0, 4'h0, 0, 1, 0));
        step("steal1", 0, mk(1, 32'h301, 4'hF, 4'h0, 4'h1, 0, 1, 1));
        step("steal2", 0, mk(1, 32'h302, 4'hF, 4'h0, 4'h1, 0, 1, 1));
        step("steal3", 0, mk(1, 32'h303, 4'hF, 4'h0, 4'h2, 1, 1, 1));
        step("steal4", 0, mk(1, 32'h304, 4'hB, 4'h0, 4'h2, 1, 1, 1));
        step("steal_lock", 0, mk(0, 0, 4'hB, 4'h0, 4'h4, 2, 0, 1));
        step("steal_done", 0, mk(0, 0, 4'hB, 4'h1, 4'h4, 2, 0, 1));
        step("steal_hold", 0, mk(0, 0, 4'hB, 4'h0, 4'h4, 2, 0, 1));
        step("steal_hs", 0, mk(0, 0, 4'hF, 4'h0, 4'h4, 2, 1, 1));
        step("steal_ret0", 0, mk(0, 0, 4'hF, 4'h3, 4'h0, 0, 1, 1));
        step("steal_ret1", 0, mk(0, 0, 4'hF, 4'h6, 4'h0, 0, 1, 1));
        step("steal_idle", 0, mk(0, 0, 4'hF, 4'h0, 4'h0, 0, 1, 0));

        // Handshake and done on target 1 together keep its count at 1.
        step("simul0", 0, mk(1, 32'h400, 4'hF, 4'h0, 4'h0, 0, 1, 0));
        step("simul1", 0, mk(1, 32'h401, 4'hF, 4'h0, 4'h1, 0, 1, 1));
        step("simul2", 0, mk(1, 32'h402, 4'hF, 4'h0, 4'h1, 0, 1, 1));
        step("simul3", 0, mk(1, 32'h403, 4'hF, 4'h0, 4'h2, 1, 1, 1));
        step("simul_hd", 0, mk(1, 32'h404, 4'hF, 4'h2, 4'h2, 1, 1, 1));
        step("simul_next", 0, mk(0, 0, 4'hF, 4'h0, 4'h2, 1, 1, 1));
        step("simul_full", 0, mk(0, 0, 4'hF, 4'h3, 4'h0, 2, 1, 1));
        step("simul_ret", 0, mk(0, 0, 4'hF, 4'h3, 4'h0, 0, 1, 1));
        step("simul_idle", 0, mk(0, 0, 4'hF, 4'h0, 4'h0, 0, 1, 0));

        // Flush while locked with one item in flight on target 0.
        step("flush0", 0, mk(1, 32'h500, 4'hF, 4'h0, 4'h0, 0, 1, 0));
        step("flush1", 0, mk(1, 32'h501, 4'hF, 4'h0, 4'h1, 0, 1, 1));
        step("flush_lock", 0, mk(0, 0, 4'hE, 4'h0, 4'h1, 0, 0, 1));
        step("flush_go", 1, mk(0, 0, 4'hE, 4'h0, 4'h1, 0, 0, 1));
        step("flush_after", 0, mk(0, 0, 4'hF, 4'h0, 4'h0, 0, 1, 1));
        step("flush_ret", 0, mk(0, 0, 4'hF, 4'h1, 4'h0, 0, 1, 1));
        step("flush_drop", 1, mk(1, 32'h599, 4'hF, 4'h0, 4'h0, 0, 1, 0));
        step("flush_dropped", 0, mk(0, 0, 4'hF, 4'h0, 4'h0, 0, 1, 0));

        check("sb_drain", DW'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
